// File: rtl/ddr2fifo_buf.sv
// ddr2fifo_buf
// Read-side DDR buffer: collects 128-bit DDR read beats in a 2^AW x 128-bit
// RAM and streams them out as 64-bit words (low half first) over valid/ready.
// Burst read requests are only issued when the buffer can absorb a whole
// burst on top of everything already requested but not yet returned.
//
// Ports
//   clk, rst      single clock, synchronous active-high reset
//   en            allow new burst requests
//   req/req_ack   burst read request, held until acknowledged
//   ddr_rdata     128-bit read beat, qualified by ddr_rvalid
//   dout          64-bit output word, dout_vld/dout_rdy handshake
//   level         128-bit entries held (including those in the read pipeline)
//   empty         level == 0
//   ovf           sticky: beat dropped because the buffer was full
//   err           sticky: beat arrived with no burst outstanding
module ddr2fifo_buf #(
    parameter int AW    = 6,
    parameter int BURST = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic          req,
    input  logic          req_ack,
    input  logic [127:0]  ddr_rdata,
    input  logic          ddr_rvalid,
    output logic [63:0]   dout,
    output logic          dout_vld,
    input  logic          dout_rdy,
    output logic [AW:0]   level,
    output logic          empty,
    output logic          ovf,
    output logic          err
);
    localparam int D = 1 << AW;
    localparam logic [AW:0]   DEPTH   = (AW+1)'(D);
    localparam logic [AW:0]   BURST_N = (AW+1)'(BURST);
    localparam logic [AW+1:0] DEPTH_X = (AW+2)'(D);
    localparam logic [AW+1:0] BURST_X = (AW+2)'(BURST);

    typedef enum logic {S_IDLE, S_REQ} state_t;

    logic [127:0]  mem [D];

    logic [AW-1:0] wp_q, fp_q;      // write pointer, RAM fetch pointer
    logic [AW:0]   level_q, level_d;
    logic [AW:0]   outst_q, outst_d; // beats requested but not yet returned
    logic          ovf_q, err_q;
    state_t        state_q;
    logic          req_q;

    // Stage 1: registered RAM read. Stage 2: output register holding a full
    // entry; hi_q selects which half is currently presented.
    logic [127:0]  s1_data_q;
    logic          s1_vld_q;
    logic [127:0]  out_data_q;
    logic          out_vld_q, hi_q;

    logic          full, wr_en, xfer, pop_hi, out_load, fetch, ack, rv_hit, space_ok;
    logic [AW:0]   unfetched;

    always_comb begin
        full      = (level_q == DEPTH);
        // Full is judged on the registered level, so a pop in the same
        // cycle does not make room for this beat.
        wr_en     = ddr_rvalid && !full;
        xfer      = out_vld_q && dout_rdy;
        pop_hi    = xfer && hi_q;
        out_load  = s1_vld_q && (!out_vld_q || pop_hi);
        // Entries in stage 1 / output register stay counted in level until
        // their high half pops, so subtract them to find what is left in RAM.
        unfetched = level_q - {{AW{1'b0}}, s1_vld_q} - {{AW{1'b0}}, out_vld_q};
        fetch     = (unfetched != '0) && (!s1_vld_q || out_load);
        ack       = (state_q == S_REQ) && req_ack;
        rv_hit    = ddr_rvalid && (outst_q != '0);
        space_ok  = ({1'b0, level_q} + {1'b0, outst_q} + BURST_X) <= DEPTH_X;
        level_d   = level_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, pop_hi};
        outst_d   = outst_q + (ack ? BURST_N : '0) - {{AW{1'b0}}, rv_hit};
    end

    // Buffer RAM: one write port, one registered read port, no reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wp_q] <= ddr_rdata;
    end

    always_ff @(posedge clk) begin
        if (fetch) s1_data_q <= mem[fp_q];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q       <= '0;
            fp_q       <= '0;
            level_q    <= '0;
            outst_q    <= '0;
            ovf_q      <= 1'b0;
            err_q      <= 1'b0;
            s1_vld_q   <= 1'b0;
            out_data_q <= '0;
            out_vld_q  <= 1'b0;
            hi_q       <= 1'b0;
        end else begin
            level_q <= level_d;
            outst_q <= outst_d;
            if (wr_en) wp_q <= wp_q + AW'(1);
            if (ddr_rvalid && full) ovf_q <= 1'b1;
            if (ddr_rvalid && (outst_q == '0)) err_q <= 1'b1;

            if (fetch) begin
                fp_q     <= fp_q + AW'(1);
                s1_vld_q <= 1'b1;
            end else if (out_load) begin
                s1_vld_q <= 1'b0;
            end

            if (out_load) begin
                out_data_q <= s1_data_q;
                out_vld_q  <= 1'b1;
                hi_q       <= 1'b0;
            end else if (xfer) begin
                if (!hi_q) begin
                    hi_q <= 1'b1;
                end else begin
                    out_vld_q <= 1'b0;
                    hi_q      <= 1'b0;
                end
            end
        end
    end

    // Request FSM: req is registered and held until acknowledged.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (en && space_ok) begin
                        state_q <= S_REQ;
                        req_q   <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (req_ack) begin
                        state_q <= S_IDLE;
                        req_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign req      = req_q;
    assign dout     = hi_q ? out_data_q[127:64] : out_data_q[63:0];
    assign dout_vld = out_vld_q;
    assign level    = level_q;
    assign empty    = (level_q == '0);
    assign ovf      = ovf_q;
    assign err      = err_q;

endmodule
